alu_execute_stage: RTL and testbench

// Execute stage sitting between register_bank read ports and its write port. Accepts an op plus

---
 rtl/alu_execute_stage.sv | 160 ++++++++++++++++
 tb/tb_alu_execute_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_execute_stage.sv
// Execute stage: one-cycle ALU ops with a registered writeback pulse toward the register bank.
// Define ALU_MUL_EN to build op 111 as an iterative shift-add unsigned multiply; otherwise op 111 raises illegal.
module alu_execute_stage #(
  parameter int WIDTH     = 8,
  parameter int ADD_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     rs1_data,
  input  logic [WIDTH-1:0]     rs2_data,
  input  logic [ADD_WIDTH-1:0] rd,
  output logic                 wb_en,
  output logic [ADD_WIDTH-1:0] wb_reg,
  output logic [WIDTH-1:0]     wb_data,
  output logic                 zero,
  output logic                 carry,
  output logic                 busy,
  output logic                 illegal
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL1 = 3'b101;
  localparam logic [2:0] OP_SHR1 = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  // Returns {carry, result}; bit WIDTH of the widened subtract is the unsigned borrow.
  function automatic logic [WIDTH:0] alu_calc(input logic [2:0] f,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = '0;
    case (f)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_SHL1: r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      OP_SHR1: r = {a[0], 1'b0, a[WIDTH-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic                 accept;
  logic                 is_mul;
  logic [WIDTH:0]       calc_p0;
  logic                 launch_p0;
  logic [WIDTH-1:0]     res_p0;
  logic                 carry_p0;
  logic [ADD_WIDTH-1:0] dest_p0;
  logic                 illegal_p0;

  assign accept  = in_valid & in_ready;
  assign is_mul  = (op == OP_MUL);
  assign calc_p0 = alu_calc(op, rs1_data, rs2_data);

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_WB_MUL} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0]     mul_cnt;
  logic [2*WIDTH-1:0]   mul_a_p1;
  logic [WIDTH-1:0]     mul_b_p1;
  logic [2*WIDTH-1:0]   mul_acc_p1;
  logic [ADD_WIDTH-1:0] mul_rd_p1;
  logic [2*WIDTH-1:0]   step_acc;
  logic                 mul_done;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept && is_mul) state_d = S_MULT;
      S_MULT:   if (mul_cnt == CNT_W'(WIDTH-1)) state_d = S_WB_MUL;
      S_WB_MUL: state_d = (accept && is_mul) ? S_MULT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // WB_MUL only carries the already-launched pulse, so the stage can accept again there.
  always_comb begin
    busy     = (state_q == S_MULT);
    in_ready = (state_q != S_MULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                 mul_cnt <= '0;
    else if (accept)            mul_cnt <= '0;
    else if (state_q == S_MULT) mul_cnt <= mul_cnt + 1'b1;
  end

  assign step_acc = mul_acc_p1 + (mul_b_p1[0] ? mul_a_p1 : '0);
  assign mul_done = (state_q == S_MULT) && (mul_cnt == CNT_W'(WIDTH-1));

  // ---- stage p1: multiplier operand/accumulator registers ----
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mul_a_p1   <= {{WIDTH{1'b0}}, rs1_data};
      mul_b_p1   <= rs2_data;
      mul_acc_p1 <= '0;
      mul_rd_p1  <= rd;
    end else if (state_q == S_MULT) begin
      mul_a_p1   <= mul_a_p1 << 1;
      mul_b_p1   <= mul_b_p1 >> 1;
      mul_acc_p1 <= step_acc;
    end
  end

  // Final step result feeds writeback directly so the pulse lands in WB_MUL.
  assign launch_p0  = (accept && !is_mul) || mul_done;
  assign res_p0     = mul_done ? step_acc[WIDTH-1:0] : calc_p0[WIDTH-1:0];
  assign carry_p0   = mul_done ? (|step_acc[2*WIDTH-1:WIDTH]) : calc_p0[WIDTH];
  assign dest_p0    = mul_done ? mul_rd_p1 : rd;
  assign illegal_p0 = 1'b0;
`else
  assign busy       = 1'b0;
  assign in_ready   = 1'b1;
  assign launch_p0  = accept && !is_mul;
  assign res_p0     = calc_p0[WIDTH-1:0];
  assign carry_p0   = calc_p0[WIDTH];
  assign dest_p0    = rd;
  assign illegal_p0 = accept && is_mul;
`endif

  // ---- stage p0 -> writeback registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en   <= 1'b0;
      wb_reg  <= '0;
      wb_data <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      wb_en   <= launch_p0 && (dest_p0 != '0);
      illegal <= illegal_p0;
      if (launch_p0) begin
        wb_reg  <= dest_p0;
        wb_data <= res_p0;
        zero    <= (res_p0 == '0);
        carry   <= carry_p0;
      end
    end
  end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed bench for alu_execute_stage: table of single-cycle ALU vectors plus multi-cycle sequences.
module tb_alu_execute_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] rs1_data, rs2_data;
  logic [4:0] rd;
  logic       wb_en;
  logic [4:0] wb_reg;
  logic [7:0] wb_data;
  logic       zero, carry, busy, illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_execute_stage #(.WIDTH(8), .ADD_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .zero(zero), .carry(carry), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] rd;
    logic       en;
    logic [7:0] data;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs [0:12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic [4:0] r);
    in_valid = v; op = o; rs1_data = a; rs2_data = b; rd = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wb_en"},    wb_en,    0);
    chk({tag, ".wb_reg"},   wb_reg,   0);
    chk({tag, ".wb_data"},  wb_data,  0);
    chk({tag, ".zero"},     zero,     0);
    chk({tag, ".carry"},    carry,    0);
    chk({tag, ".busy"},     busy,     0);
    chk({tag, ".illegal"},  illegal,  0);
    chk({tag, ".in_ready"}, in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //           op      a      b      rd  en data   z  c
    vecs[0]  = '{3'b000, 8'hF0, 8'h20, 3,  1, 8'h10, 0, 1};
    vecs[1]  = '{3'b001, 8'h05, 8'h05, 2,  1, 8'h00, 1, 0};
    vecs[2]  = '{3'b001, 8'h03, 8'h04, 2,  1, 8'hFF, 0, 1};
    vecs[3]  = '{3'b101, 8'h81, 8'h00, 1,  1, 8'h02, 0, 1};
    vecs[4]  = '{3'b110, 8'h01, 8'h00, 1,  1, 8'h00, 1, 1};
    vecs[5]  = '{3'b010, 8'hFF, 8'h0F, 0,  0, 8'h0F, 0, 0};
    vecs[6]  = '{3'b011, 8'h50, 8'h0A, 7,  1, 8'h5A, 0, 0};
    vecs[7]  = '{3'b100, 8'hAA, 8'hAA, 31, 1, 8'h00, 1, 0};
    vecs[8]  = '{3'b000, 8'hFF, 8'h01, 4,  1, 8'h00, 1, 1};
    vecs[9]  = '{3'b000, 8'h12, 8'h34, 0,  0, 8'h46, 0, 0};
    vecs[10] = '{3'b001, 8'h80, 8'h01, 6,  1, 8'h7F, 0, 0};
    vecs[11] = '{3'b110, 8'h80, 8'hFF, 9,  1, 8'h40, 0, 0};
    vecs[12] = '{3'b101, 8'h7F, 8'h00, 10, 1, 8'hFE, 0, 0};

    rst_n = 1'b0;
    drive(0, 3'b000, 8'h00, 8'h00, 5'd0);
    step(); step();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Back-to-back accepts: each result must appear in the cycle right after its edge.
    for (int i = 0; i < 13; i++) begin
      drive(1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      chk($sformatf("v%0d.in_ready", i), in_ready, 1);
      step();
      chk($sformatf("v%0d.wb_en", i), wb_en, vecs[i].en);
      chk($sformatf("v%0d.zero", i), zero, vecs[i].z);
      chk($sformatf("v%0d.carry", i), carry, vecs[i].c);
      chk($sformatf("v%0d.illegal", i), illegal, 0);
      if (vecs[i].en) begin
        chk($sformatf("v%0d.wb_reg", i), wb_reg, vecs[i].rd);
        chk($sformatf("v%0d.wb_data", i), wb_data, vecs[i].data);
      end
    end

    // Idle: no pulse, last result and flags hold.
    drive(0, 3'b000, 8'h00, 8'h00, 5'd0);
    step();
    chk("idle.wb_en", wb_en, 0);
    chk("idle.wb_reg", wb_reg, 10);
    chk("idle.wb_data", wb_data, 8'hFE);
    chk("idle.zero", zero, 0);
    chk("idle.carry", carry, 0);

`ifdef ALU_MUL_EN
    // MUL 0x0C*0x0B: in_valid held throughout busy must not re-accept.
    drive(1, 3'b111, 8'h0C, 8'h0B, 5'd5);
    step();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("mul1.c%0d.in_ready", k), in_ready, 0);
      chk($sformatf("mul1.c%0d.busy", k), busy, 1);
      chk($sformatf("mul1.c%0d.wb_en", k), wb_en, 0);
      step();
    end
    chk("mul1.wb_en", wb_en, 1);
    chk("mul1.wb_reg", wb_reg, 5);
    chk("mul1.wb_data", wb_data, 8'h84);
    chk("mul1.carry", carry, 0);
    chk("mul1.zero", zero, 0);
    chk("mul1.in_ready", in_ready, 1);
    chk("mul1.busy", busy, 0);
    drive(0, 3'b000, 8'h00, 8'h00, 5'd0);
    step();
    chk("mul1.after.wb_en", wb_en, 0);
    chk("mul1.after.busy", busy, 0);
    step();
    chk("mul1.after2.wb_en", wb_en, 0);

    // MUL 0x10*0x10 overflows entirely into the upper half.
    drive(1, 3'b111, 8'h10, 8'h10, 5'd6);
    step();
    drive(0, 3'b000, 8'h00, 8'h00, 5'd0);
    for (int k = 0; k < 8; k++) step();
    chk("mul2.wb_en", wb_en, 1);
    chk("mul2.wb_reg", wb_reg, 6);
    chk("mul2.wb_data", wb_data, 8'h00);
    chk("mul2.carry", carry, 1);
    chk("mul2.zero", zero, 1);
    chk("mul2.illegal", illegal, 0);

    // Reset during the 4th multiply step aborts without writeback.
    drive(1, 3'b111, 8'hFF, 8'hFF, 5'd7);
    step();
    drive(0, 3'b000, 8'h00, 8'h00, 5'd0);
    step(); step(); step();
    chk("rmul.busy_before", busy, 1);
    rst_n = 1'b0;
    step();
    chk_all_zero("rmul");
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 12; k++) begin
        step();
        if (wb_en) seen++;
      end
      chk("rmul.no_wb", seen, 0);
    end
    chk("rmul.in_ready", in_ready, 1);
`else
    // Op 111 without the multiplier: illegal pulse, no write, flags untouched.
    drive(1, 3'b111, 8'h0C, 8'h0B, 5'd5);
    chk("ill.in_ready", in_ready, 1);
    step();
    chk("ill.illegal", illegal, 1);
    chk("ill.wb_en", wb_en, 0);
    chk("ill.wb_data", wb_data, 8'hFE);
    chk("ill.zero", zero, 0);
    chk("ill.carry", carry, 0);
    chk("ill.busy", busy, 0);
    chk("ill.in_ready_after", in_ready, 1);
    drive(1, 3'b000, 8'h01, 8'h02, 5'd8);
    step();
    chk("ill.next.illegal", illegal, 0);
    chk("ill.next.wb_en", wb_en, 1);
    chk("ill.next.wb_reg", wb_reg, 8);
    chk("ill.next.wb_data", wb_data, 8'h03);
    drive(0, 3'b000, 8'h00, 8'h00, 5'd0);
    step();
    chk("ill.idle.wb_en", wb_en, 0);
`endif

    // Reset right after a result with a carry clears everything.
    drive(1, 3'b000, 8'hF0, 8'h20, 5'd3);
    step();
    chk("radd.carry_pre", carry, 1);
    drive(1, 3'b000, 8'hF0, 8'h20, 5'd3);
    rst_n = 1'b0;
    step();
    chk_all_zero("radd");
    rst_n = 1'b1;
    drive(0, 3'b000, 8'h00, 8'h00, 5'd0);
    step();
    chk("radd.after.wb_en", wb_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
